// File: rtl/spi_prog_pkg.sv
// Shared types for the program/run serial master: frame layout, FSM states, command kinds.
// Pure declarations; no timing or flow control of its own.
package spi_prog_pkg;

  localparam int FRAME_W   = 12;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 4;
  localparam int RUN_CNT_W = 16;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_RUN   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_GAP,
    S_START,
    S_WAIT,
    S_ABORT
  } state_t;

  // Address occupies the low bits so it reaches the core's shift register first.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } frame_t;

  function automatic frame_t make_frame(input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
    frame_t f;
    f.data = data;
    f.addr = addr;
    return f;
  endfunction

endpackage

// File: rtl/piso_reg.sv
// Parallel-load, LSB-first shift register; sout shows bit 0, one bit consumed per shift cycle.
// Load wins over shift; no backpressure, the caller sequences load/shift.
module piso_reg
  import spi_prog_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift,
  output logic         sout
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_dat;
    end else if (shift) begin
      sr_d = {1'b0, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout = sr_q[0];

endmodule

// File: rtl/spi_prog_master.sv
// Host master for the core's serial program/run port: 12-bit LSB-first instruction frames and bounded runs.
// Write occupies 14+GAP cycles, run START+WAIT(+ABORT); cmd_ready only in IDLE, so commands stall until then.
module spi_prog_master
  import spi_prog_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_run,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_data,
  output logic                 csi_n,
  output logic                 csd_n,
  output logic                 mosi,
  output logic                 proc_en,
  input  logic                 done_in,
  output logic                 run_done,
  output logic                 run_timeout,
  output logic [RUN_CNT_W-1:0] run_cycles
);

  if (GAP < 2) begin : g_bad_gap
    $error("spi_prog_master: GAP must be at least 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("spi_prog_master: TIMEOUT must be in 1..65535");
  end

  localparam logic [RUN_CNT_W-1:0] TIMEOUT_C = RUN_CNT_W'(TIMEOUT);
  localparam logic [RUN_CNT_W-1:0] GAP_LAST  = RUN_CNT_W'(GAP - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_W - 1);

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RUN_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [RUN_CNT_W-1:0]   run_cycles_q, run_cycles_d;
  logic                   run_done_q, run_done_d;
  logic                   run_timeout_q, run_timeout_d;

  logic                   accept;
  logic                   frame_load;
  logic                   frame_shift;
  logic                   frame_bit;
  logic [RUN_CNT_W-1:0]   run_cnt_inc;
  frame_t                 frame;

  assign cmd_ready   = (state_q == S_IDLE) & ~rst;
  assign accept      = cmd_valid & cmd_ready;
  assign frame       = make_frame(cmd_addr, cmd_data);
  assign frame_load  = accept & (cmd_run == CMD_WRITE);
  assign run_cnt_inc = run_cnt_q + RUN_CNT_W'(1);

  piso_reg #(
    .W(FRAME_W)
  ) u_frame (
    .clk      (clk),
    .rst      (rst),
    .load     (frame_load),
    .load_dat (frame),
    .shift    (frame_shift),
    .sout     (frame_bit)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    run_cnt_d     = run_cnt_q;
    run_cycles_d  = run_cycles_q;
    run_done_d    = 1'b0;
    run_timeout_d = 1'b0;
    csi_n         = 1'b1;
    mosi          = 1'b0;
    proc_en       = 1'b0;
    frame_shift   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          run_cnt_d = '0;
          state_d   = (cmd_run == CMD_RUN) ? S_START : S_SEL;
        end
      end

      // The core leaves IDLE on this cycle; data starts on the next one.
      S_SEL: begin
        csi_n   = 1'b0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        csi_n       = 1'b0;
        mosi        = frame_bit;
        frame_shift = 1'b1;
        bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == BIT_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end

      // Core needs RECV->WRITE->IDLE with csi high before the next frame.
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + RUN_CNT_W'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        proc_en   = 1'b1;
        run_cnt_d = '0;
        state_d   = S_WAIT;
      end

      // Enable follows done_in combinationally so the core cannot re-enter EXEC.
      S_WAIT: begin
        proc_en   = ~done_in;
        run_cnt_d = run_cnt_inc;
        if (done_in) begin
          run_done_d   = 1'b1;
          run_cycles_d = run_cnt_inc;
          state_d      = S_IDLE;
        end else if (run_cnt_inc == TIMEOUT_C) begin
          run_timeout_d = 1'b1;
          run_cycles_d  = TIMEOUT_C;
          state_d       = S_ABORT;
        end
      end

      S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      run_cnt_q     <= '0;
      run_cycles_q  <= '0;
      run_done_q    <= 1'b0;
      run_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      run_cnt_q     <= run_cnt_d;
      run_cycles_q  <= run_cycles_d;
      run_done_q    <= run_done_d;
      run_timeout_q <= run_timeout_d;
    end
  end

  assign csd_n       = 1'b1;
  assign run_done    = run_done_q;
  assign run_timeout = run_timeout_q;
  assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_spi_prog_master.sv
// Bench for spi_prog_master: directed + randomized writes and runs against a frame-collecting core model.
module tb_spi_prog_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_run, done_in;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_ready, csi_n, csd_n, mosi, proc_en, run_done, run_timeout;
  logic [15:0] run_cycles;

  logic        cmd_valid2, cmd_run2, done_in2;
  logic        cmd_ready2, csi_n2, csd_n2, mosi2, proc_en2, run_done2, run_timeout2;
  logic [15:0] run_cycles2;

  always #5 clk = ~clk;

  spi_prog_master #(.TIMEOUT(255), .GAP(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_run(cmd_run), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi), .proc_en(proc_en),
    .done_in(done_in), .run_done(run_done), .run_timeout(run_timeout),
    .run_cycles(run_cycles)
  );

  spi_prog_master #(.TIMEOUT(8), .GAP(2)) dut_to (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_run(cmd_run2), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .csi_n(csi_n2), .csd_n(csd_n2), .mosi(mosi2), .proc_en(proc_en2),
    .done_in(done_in2), .run_done(run_done2), .run_timeout(run_timeout2),
    .run_cycles(run_cycles2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Core model: every bit seen while csi_n is low, after the select cycle, is a frame bit.
  logic [7:0]  imem [16];
  logic [7:0]  exp_mem [16];
  bit          in_frame = 1'b0;
  bit          bits_q [$];
  logic [11:0] word_tmp;
  int          en_rises = 0, en_rises2 = 0, to_pulses2 = 0, runs = 0;
  bit          pe_prev = 1'b0, pe_prev2 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      bits_q.delete();
    end else if (!csi_n) begin
      if (in_frame) bits_q.push_back(mosi);
      in_frame = 1'b1;
    end else if (in_frame) begin
      in_frame = 1'b0;
      if (bits_q.size() == 12) begin
        for (int i = 0; i < 12; i++) word_tmp[i] = bits_q[i];
        imem[word_tmp[3:0]] = word_tmp[11:4];
      end
      bits_q.delete();
    end
    if (proc_en && !pe_prev) en_rises++;
    pe_prev = proc_en;
    if (proc_en2 && !pe_prev2) en_rises2++;
    pe_prev2 = proc_en2;
    if (run_timeout2) to_pulses2++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      step();
      #1;
      n++;
    end
    if (n == 50) chk("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Called right after the accepting edge; leaves time inside cycle 16 (IDLE again).
  task automatic write_body(input logic [3:0] a, input logic [7:0] d);
    logic [11:0] sh;
    int          lo;
    logic        exp_mosi;
    sh = {d, a};
    lo = 0;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      exp_mosi = 1'b0;
      if (c >= 2 && c <= 13) begin
        exp_mosi = sh[0];
        sh = sh >> 1;
      end
      chk("wr_csi_n", 32'(csi_n), (c <= 13) ? 32'd0 : 32'd1);
      chk("wr_mosi", 32'(mosi), 32'(exp_mosi));
      chk("wr_proc_en", 32'(proc_en), 32'd0);
      if (cmd_ready !== 1'b1) lo++;
      if (c < 16) step();
    end
    chk("wr_ready_back", 32'(cmd_ready), 32'd1);
    chk("wr_ready_low_cycles", 32'(lo), 32'd15);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_run   = 1'b0;
    cmd_addr  = a;
    cmd_data  = d;
    exp_mem[a] = d;
    step();
    write_body(a, d);
  endtask

  // Run with done_in low for n_lo WAIT cycles, high on the next; optionally keep a write pending.
  task automatic run_main(input int n_lo, input bit hold_next, input logic [3:0] a, input logic [7:0] d);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_run   = 1'b1;
    done_in   = 1'b1;
    step();
    runs++;
    if (hold_next) begin
      cmd_run  = 1'b0;
      cmd_addr = a;
      cmd_data = d;
    end else begin
      cmd_valid = 1'b0;
    end
    #1;
    chk("run_start_en", 32'(proc_en), 32'd1);
    chk("run_start_ready", 32'(cmd_ready), 32'd0);
    for (int w = 1; w <= n_lo; w++) begin
      step();
      done_in = 1'b0;
      #1;
      chk("run_wait_en", 32'(proc_en), 32'd1);
      chk("run_wait_csi", 32'(csi_n), 32'd1);
      chk("run_wait_ready", 32'(cmd_ready), 32'd0);
      chk("run_wait_done", 32'(run_done), 32'd0);
    end
    step();
    done_in = 1'b1;
    #1;
    chk("run_en_drop", 32'(proc_en), 32'd0);
    chk("run_last_csi", 32'(csi_n), 32'd1);
    step();
    #1;
    chk("run_done_pulse", 32'(run_done), 32'd1);
    chk("run_cycles", 32'(run_cycles), 32'(n_lo + 1));
    chk("run_idle_en", 32'(proc_en), 32'd0);
    chk("run_idle_ready", 32'(cmd_ready), 32'd1);
    if (hold_next) begin
      exp_mem[a] = d;
      step();
      write_body(a, d);
    end else begin
      step();
      #1;
      chk("run_done_clear", 32'(run_done), 32'd0);
      chk("run_cycles_held", 32'(run_cycles), 32'(n_lo + 1));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] f;
    rst = 1'b1; cmd_valid = 1'b0; cmd_run = 1'b0; cmd_addr = '0; cmd_data = '0; done_in = 1'b1;
    cmd_valid2 = 1'b0; cmd_run2 = 1'b1; done_in2 = 1'b0;
    for (int i = 0; i < 16; i++) begin imem[i] = '0; exp_mem[i] = '0; end

    repeat (2) step();
    #1;
    chk("rst_csi_n", 32'(csi_n), 32'd1);
    chk("rst_csd_n", 32'(csd_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_proc_en", 32'(proc_en), 32'd0);
    chk("rst_run_done", 32'(run_done), 32'd0);
    chk("rst_run_timeout", 32'(run_timeout), 32'd0);
    chk("rst_run_cycles", 32'(run_cycles), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_proc_en2", 32'(proc_en2), 32'd0);
    rst = 1'b0;
    step();
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_ready2", 32'(cmd_ready2), 32'd1);

    do_write(4'h3, 8'hA5);
    do_write(4'h0, 8'h11);
    do_write(4'h1, 8'h22);
    repeat (6) do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));

    run_main(20, 1'b1, 4'h5, 8'h5A);
    run_main(int'($urandom_range(0, 40)), 1'b0, 4'h0, 8'h00);
    run_main(int'($urandom_range(0, 40)), 1'b0, 4'h0, 8'h00);
    chk("exec_entries", 32'(en_rises), 32'(runs));

    // Timeout instance: done_in2 stuck low.
    #1;
    cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    #1;
    chk("to_start_en", 32'(proc_en2), 32'd1);
    for (int w = 1; w <= 8; w++) begin
      step();
      #1;
      chk("to_wait_en", 32'(proc_en2), 32'd1);
      chk("to_wait_flag", 32'(run_timeout2), 32'd0);
    end
    step();
    #1;
    chk("to_abort_en", 32'(proc_en2), 32'd0);
    chk("to_abort_pulse", 32'(run_timeout2), 32'd1);
    chk("to_abort_cycles", 32'(run_cycles2), 32'd8);
    chk("to_abort_ready", 32'(cmd_ready2), 32'd0);
    step();
    #1;
    chk("to_idle_pulse", 32'(run_timeout2), 32'd0);
    chk("to_idle_ready", 32'(cmd_ready2), 32'd1);
    chk("to_idle_en", 32'(proc_en2), 32'd0);
    chk("to_idle_done", 32'(run_done2), 32'd0);
    chk("to_pulse_count", 32'(to_pulses2), 32'd1);
    chk("to_exec_entries", 32'(en_rises2), 32'd1);

    // Reset during SHIFT bit 5 of a write to an already-programmed address.
    wait_ready();
    f = {~exp_mem[3], 4'h3};
    cmd_valid = 1'b1; cmd_run = 1'b0; cmd_addr = 4'h3; cmd_data = ~exp_mem[3];
    step();
    cmd_valid = 1'b0;
    repeat (6) step();
    #1;
    chk("rstw_csi_before", 32'(csi_n), 32'd0);
    chk("rstw_bit5", 32'(mosi), 32'(f[5]));
    rst = 1'b1;
    step();
    #1;
    chk("rstw_csi", 32'(csi_n), 32'd1);
    chk("rstw_mosi", 32'(mosi), 32'd0);
    chk("rstw_en", 32'(proc_en), 32'd0);
    chk("rstw_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstw_ready_after", 32'(cmd_ready), 32'd1);
    step();
    #1;
    chk("rstw_csi_idle", 32'(csi_n), 32'd1);

    // Reset mid-run drops the enable.
    cmd_valid = 1'b1; cmd_run = 1'b1; done_in = 1'b1;
    step();
    runs++;
    cmd_valid = 1'b0;
    repeat (3) begin step(); done_in = 1'b0; end
    #1;
    chk("rstr_en_before", 32'(proc_en), 32'd1);
    rst = 1'b1;
    step();
    #1;
    chk("rstr_en", 32'(proc_en), 32'd0);
    chk("rstr_cycles", 32'(run_cycles), 32'd0);
    rst = 1'b0;
    done_in = 1'b1;
    step();
    #1;
    chk("exec_entries_final", 32'(en_rises), 32'(runs));

    for (int i = 0; i < 16; i++) chk($sformatf("imem_%0d", i), 32'(imem[i]), 32'(exp_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
